lvds_word_aligner: RTL and testbench
====================================

// Module: lvds_word_aligner
// PURPOSE
//  Sits directly downstream of the 8:1 ISERDESE3 deserializer in the LVDS receive path, on the
//  CLKDIV (rxdivclk) domain. The deserializer emits 8-bit words with arbitrary bit phase.
//  This block finds the word boundary by searching all 8 bit offsets for a training pattern,
//  verifies the boundary over several consecutive words, then outputs byte-aligned data.
//  No ISERDES BITSLIP is used: alignment is a barrel shift over a two-word history.
// PARAMETERS
//  TRAIN_PATTERN  8'hF0  training word; its 8 rotations are all distinct, so exactly one offset matches
//  LOCK_COUNT     16     consecutive matching words at one offset required to declare lock (2..255)
// PORTS
//  clk          in   1   rxdivclk (ISERDES CLKDIV); the only clock
//  resetn       in   1   synchronous active-low reset
//  rxdata       in   8   ISERDES Q output; a new word is presented every clk
//  realign      in   1   single-cycle pulse; drop lock and restart the search
//  dout         out  8   aligned word
//  dout_valid   out  1   high while locked; dout is a payload word
//  locked       out  1   alignment established
//  offset       out  3   selected bit offset (0..7)
//  verify_fail  out  16  saturating count of VERIFY->SEARCH fallbacks since reset
// BEHAVIOUR
//  Datapath:
//  - d1 <= rxdata; d2 <= d1; hist[15:0] = {d1,d2}; win(k) = hist[k+7:k], k = 0..7.
//  - dout <= win(offset) every clk, in all states.
//  - Fixed latency for offset 0: rxdata word -> dout is 3 clk.
//  Match detection:
//  - match[k] = (win(k) == TRAIN_PATTERN), evaluated combinationally from hist.
//  - If several match[k] are high, the lowest k wins.
//  FSM states: SEARCH, VERIFY, LOCKED. cnt is an 8-bit counter.
//  - SEARCH: when any match[k] is high -> offset <= k, cnt <= 1, go to VERIFY. Otherwise stay.
//  - VERIFY: if match[offset] is high, cnt <= cnt+1; when cnt+1 == LOCK_COUNT -> LOCKED.
//  - VERIFY: if match[offset] is low -> SEARCH, cnt <= 0, verify_fail += 1 (saturates at 16'hFFFF).
//  - LOCKED: stays LOCKED regardless of data, since payload is not checked. Exits only on realign or reset.
//  - realign: from any state -> SEARCH, cnt <= 0. realign has priority over a match in the same cycle.
//    In SEARCH it has no effect beyond holding SEARCH.
//  Outputs:
//  - locked and dout_valid are registered; both high exactly while state == LOCKED.
//  - They rise the cycle after the LOCK_COUNT-th consecutive match.
//  - They fall the cycle after a realign pulse.
//  - offset holds its value while LOCKED and after leaving LOCKED, until the next SEARCH hit.
//  Reset (resetn = 0 at a clk edge):
//  - state = SEARCH; d1, d2, dout = 0; offset = 0; cnt = 0; locked, dout_valid = 0; verify_fail = 0.
//  - Reset mid-VERIFY or mid-LOCKED discards all progress; the search restarts with cleared history.
//  Widths: LOCK_COUNT compare is 8 bits; cnt never exceeds LOCK_COUNT.
// TESTING
//  1. Serial stream of repeated 8'hF0, bit-shifted by 3 into rxdata, LOCK_COUNT=16
//     -> offset=3; locked rises 16 clk after the first matching hist; dout=8'hF0 with dout_valid=1.
//  2. Sweep the shift over 0..7 with repeated F0
//     -> offset equals the shift each run; dout=F0 once locked.
//  3. F0 stream at offset 5 with one corrupted word injected after 10 matches
//     -> returns to SEARCH; verify_fail=1; relocks after a further 16 good words; locked never high early.
//  4. Locked at offset 2, then incrementing payload 00..FF
//     -> dout shows 00,01,.. in order, 3-clk latency shift-adjusted; locked stays high.
//     -> realign pulse -> locked=0 next cycle; relocks on a subsequent F0 stream.
//  5. rxdata constant 8'h00 (no training)
//     -> stays in SEARCH; locked=0; verify_fail=0.
//  6. resetn low for 1 clk mid-LOCKED
//     -> all outputs 0 next cycle; relock requires a full LOCK_COUNT of matches.

Source files
------------

// File: rtl/lvds_word_aligner.sv
// Word aligner for an 8:1 deserialized LVDS lane: searches all 8 bit offsets for a
// training word, verifies the boundary over consecutive words, then emits aligned data.
module lvds_word_aligner #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'hF0,
  parameter int unsigned LOCK_COUNT    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rxdata,
  input  logic        realign,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [2:0]  offset,
  output logic [15:0] verify_fail
);

  localparam logic [7:0] LOCK_CNT = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic [7:0]  d1_p0;
  logic [7:0]  d2_p1;
  logic [15:0] hist;
  logic [7:0]  match;
  logic        hit_any;
  logic [2:0]  hit_k;
  logic [7:0]  win_sel;

  assign hist     = {d1_p0, d2_p1};
  assign cnt_next = cnt + 8'd1;
  assign win_sel  = hist[offset +: 8];

  // Scan from the top down so the lowest matching offset is the one left in hit_k.
  always_comb begin
    match   = '0;
    hit_k   = '0;
    for (int k = 0; k < 8; k++) begin
      match[k] = (hist[k +: 8] == TRAIN_PATTERN);
    end
    hit_any = |match;
    for (int k = 7; k >= 0; k--) begin
      if (match[k]) hit_k = 3'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      d1_p0       <= '0;
      d2_p1       <= '0;
      dout        <= '0;
      state       <= SEARCH;
      cnt         <= '0;
      offset      <= '0;
      locked      <= 1'b0;
      dout_valid  <= 1'b0;
      verify_fail <= '0;
    end else begin
      // stage p0/p1: two-word history; stage p2: barrel-shifted output
      d1_p0 <= rxdata;
      d2_p1 <= d1_p0;
      dout  <= win_sel;

      case (state)
        SEARCH: begin
          if (realign) begin
            cnt <= '0;
          end else if (hit_any) begin
            offset <= hit_k;
            cnt    <= 8'd1;
            state  <= VERIFY;
          end
        end
        VERIFY: begin
          if (realign) begin
            state <= SEARCH;
            cnt   <= '0;
          end else if (match[offset]) begin
            cnt <= cnt_next;
            if (cnt_next == LOCK_CNT) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              dout_valid <= 1'b1;
            end
          end else begin
            state       <= SEARCH;
            cnt         <= '0;
            verify_fail <= sat_inc16(verify_fail);
          end
        end
        LOCKED: begin
          if (realign) begin
            state      <= SEARCH;
            cnt        <= '0;
            locked     <= 1'b0;
            dout_valid <= 1'b0;
          end
        end
        default: begin
          state      <= SEARCH;
          cnt        <= '0;
          locked     <= 1'b0;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_word_aligner.sv
// Bench for lvds_word_aligner: random bit-shifted training/payload streams checked every
// cycle against a word-level reference model, plus literal spot checks.
module tb_lvds_word_aligner;

  localparam logic [7:0] TP = 8'hF0;
  localparam int         LC = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rxdata;
  logic        realign;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        locked;
  logic [2:0]  offset;
  logic [15:0] verify_fail;

  int total = 0;
  int bad   = 0;

  lvds_word_aligner #(.TRAIN_PATTERN(TP), .LOCK_COUNT(LC)) dut (
    .clk(clk), .resetn(resetn), .rxdata(rxdata), .realign(realign),
    .dout(dout), .dout_valid(dout_valid), .locked(locked),
    .offset(offset), .verify_fail(verify_fail)
  );

  always #5 clk = ~clk;

  // Reference model: last two received words, chosen offset, progress and mode.
  logic [7:0]  m_w1, m_w2, m_dout;
  logic [2:0]  m_off;
  logic [15:0] m_vf;
  int          m_mode;   // 0 searching, 1 verifying, 2 locked
  int          m_run;
  logic [7:0]  a_prev;   // previous aligned word fed to the serializer model

  function automatic logic [7:0] window(input logic [15:0] h, input int k);
    logic [15:0] t;
    t = h >> k;
    return t[7:0];
  endfunction

  task automatic model_update(input logic [7:0] rx, input logic re, input logic rn);
    logic [15:0] h;
    int hit;
    if (!rn) begin
      m_w1 = 0; m_w2 = 0; m_dout = 0; m_off = 0; m_vf = 0; m_mode = 0; m_run = 0;
    end else begin
      h = {m_w1, m_w2};
      m_dout = window(h, int'(m_off));
      hit = -1;
      for (int k = 0; k < 8; k++)
        if (hit < 0 && window(h, k) == TP) hit = k;
      if (m_mode == 0) begin
        if (!re && hit >= 0) begin m_off = 3'(hit); m_run = 1; m_mode = 1; end
      end else if (re) begin
        m_mode = 0; m_run = 0;
      end else if (m_mode == 1) begin
        if (window(h, int'(m_off)) == TP) begin
          m_run++;
          if (m_run == LC) m_mode = 2;
        end else begin
          m_mode = 0; m_run = 0;
          if (m_vf != 16'hFFFF) m_vf++;
        end
      end
      m_w2 = m_w1;
      m_w1 = rx;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] rx, input logic re, input logic rn);
    logic ml;
    rxdata = rx; realign = re; resetn = rn;
    @(posedge clk);
    model_update(rx, re, rn);
    #1;
    ml = (m_mode == 2);
    total++;
    if (dout !== m_dout || dout_valid !== ml || locked !== ml ||
        offset !== m_off || verify_fail !== m_vf) begin
      bad++;
      $display("FAIL cycle: got dout=%h vld=%b lock=%b off=%0d vf=%0d expected dout=%h vld=%b lock=%b off=%0d vf=%0d at %0t",
               dout, dout_valid, locked, offset, verify_fail, m_dout, ml, ml, m_off, m_vf, $time);
    end
  endtask

  // Serializer model: aligned word a lands in rxdata with a bit phase of s.
  task automatic send_word(input logic [7:0] a, input int s, input logic re);
    logic [15:0] pair;
    pair = {a, a_prev} >> (8 - s);
    a_prev = a;
    step(pair[7:0], re, 1'b1);
  endtask

  task automatic do_reset();
    a_prev = TP;
    step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_train(input int s, input int n);
    for (int i = 0; i < n; i++) send_word(TP, s, 1'b0);
  endtask

  initial begin
    int s;
    int pos;
    resetn = 1'b0; realign = 1'b0; rxdata = 8'h00; a_prev = TP;
    m_w1 = 0; m_w2 = 0; m_dout = 0; m_off = 0; m_vf = 0; m_mode = 0; m_run = 0;

    do_reset();
    do_reset();
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_vf", {16'd0, verify_fail}, 32'd0);

    // training at shift 3
    send_train(3, 30);
    check("t1_offset", {29'd0, offset}, 32'd3);
    check("t1_locked", {30'd0, locked, dout_valid}, 32'd3);
    check("t1_dout", {24'd0, dout}, 32'hF0);

    // every shift
    for (int sh = 0; sh < 8; sh++) begin
      do_reset();
      send_train(sh, 24);
      check("t2_offset", {29'd0, offset}, 32'(sh));
      check("t2_dout", {24'd0, dout}, 32'hF0);
    end

    // one corrupted word mid-verify
    do_reset();
    send_train(5, 11);
    send_word(8'h00, 5, 1'b0);
    send_train(5, 25);
    check("t3_vf", {16'd0, verify_fail}, 32'd1);
    check("t3_relock", {31'd0, locked}, 32'd1);
    check("t3_offset", {29'd0, offset}, 32'd5);
    for (int r = 0; r < 4; r++) begin
      do_reset();
      s = $urandom_range(0, 7);
      pos = $urandom_range(3, 12);
      send_train(s, pos);
      send_word(8'(~TP), s, 1'b0);
      send_train(s, 24);
    end

    // payload after lock, then realign
    do_reset();
    send_train(2, 20);
    for (int p = 0; p < 256; p++) send_word(8'(p), 2, 1'b0);
    check("t4_still_locked", {31'd0, locked}, 32'd1);
    check("t4_last_payload", {24'd0, dout}, 32'hFD);
    send_word(8'h55, 2, 1'b1);
    check("t4_unlock", {30'd0, locked, dout_valid}, 32'd0);
    send_train(2, 22);
    check("t4_relock", {31'd0, locked}, 32'd1);

    // idle line
    do_reset();
    for (int i = 0; i < 40; i++) step(8'h00, 1'b0, 1'b1);
    check("t5_locked", {31'd0, locked}, 32'd0);
    check("t5_vf", {16'd0, verify_fail}, 32'd0);

    // reset while locked
    send_train(6, 24);
    check("t6_pre_lock", {31'd0, locked}, 32'd1);
    do_reset();
    check("t6_zero", {16'd0, dout, 2'd0, locked, dout_valid, offset, 1'b0} | {16'd0, verify_fail}, 32'd0);
    send_train(6, 16);
    check("t6_early", {31'd0, locked}, 32'd0);
    send_train(6, 4);
    check("t6_relock", {31'd0, locked}, 32'd1);

    // randomized bursts of training, noise, payload and occasional realign/reset
    for (int b = 0; b < 40; b++) begin
      int len;
      int kind;
      s = $urandom_range(0, 7);
      len = $urandom_range(4, 30);
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int i = 0; i < len; i++) begin
        logic [7:0] a;
        logic re;
        a = (kind == 3 || $urandom_range(0, 15) == 0) ? 8'($urandom) : TP;
        re = ($urandom_range(0, 39) == 0);
        send_word(a, s, re);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
